// File: rtl/bp_upd_sched.sv
// Branch-update scheduler: buffers resolved branches and applies them to the fetch BHT
// by read-modify-write on the shared read port, stalling fetch when updates starve.
module bp_upd_sched #(
   parameter  int unsigned bht_size   = 256,
   parameter  int unsigned qdepth     = 4,
   parameter  int unsigned starve_max = 8,
   localparam int unsigned IW         = $clog2(bht_size),
   localparam int unsigned TW         = 48 - IW - 2
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic          upd_valid,
   output logic          upd_ready,
   input  logic [47:0]   upd_pc,
   input  logic [47:0]   upd_target,
   input  logic          upd_taken,
   input  logic          lu_req,
   output logic          lu_stall,
   output logic          bht_re,
   output logic [IW-1:0] bht_ridx,
   input  logic          bht_rvalid,
   input  logic [TW-1:0] bht_rtag,
   input  logic [1:0]    bht_rctr,
   output logic          bht_we,
   output logic [IW-1:0] bht_widx,
   output logic [TW-1:0] bht_wtag,
   output logic [47:0]   bht_wtarget,
   output logic [1:0]    bht_wctr,
   output logic          busy
);
   localparam int unsigned QW = $clog2(qdepth);
   localparam int unsigned CW = $clog2(starve_max + 1);
   localparam logic [CW-1:0] SMAX = CW'(starve_max);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t            state_q, state_d;
   logic [QW:0]       wp_q, rp_q;
   logic [45:0]       fpc_q  [qdepth];
   logic [47:0]       ftgt_q [qdepth];
   logic [qdepth-1:0] ftk_q;
   logic [45:0]       wpc_q;
   logic [47:0]       wtgt_q;
   logic              wtk_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              stall_q, stall_d, rdy_q;
   logic              empty, full, avail, rd_ok, hit, we, deny, push;
   logic [1:0]        ctr_nxt;
   logic              unused_pc;

   assign unused_pc = ^upd_pc[1:0];

   always_comb begin
      empty   = (wp_q == rp_q);
      full    = (wp_q[QW] != rp_q[QW]) && (wp_q[QW-1:0] == rp_q[QW-1:0]);
      avail   = !lu_req || stall_q;
      // The read port can be taken in IDLE or WR; RD is waiting on returned data.
      rd_ok   = !empty && avail && (state_q != RD) && !n_reset;
      deny    = !empty && (state_q != RD) && lu_req && !stall_q;
      hit     = bht_rvalid && (bht_rtag == wpc_q[45:IW]);
      // Write is formed from the returned entry in the cycle it arrives, so a
      // follow-on read issued next cycle sees the updated entry.
      we      = (state_q == RD) && (hit || wtk_q) && !n_reset;
      push    = upd_valid && upd_ready;
      ctr_nxt = 2'b10;
      if (hit) begin
         if (wtk_q) ctr_nxt = (bht_rctr == 2'b11) ? 2'b11 : bht_rctr + 2'd1;
         else       ctr_nxt = (bht_rctr == 2'b00) ? 2'b00 : bht_rctr - 2'd1;
      end
      state_d = state_q;
      case (state_q)
         IDLE:    if (rd_ok) state_d = RD;
         RD:      state_d = WR;
         WR:      state_d = rd_ok ? RD : IDLE;
         default: state_d = IDLE;
      endcase
      cnt_d = cnt_q;
      if (rd_ok)                     cnt_d = '0;
      else if (deny && cnt_q < SMAX) cnt_d = cnt_q + 1'b1;
      stall_d = rd_ok ? 1'b0 : (stall_q || (cnt_d == SMAX));
   end

   always_ff @(posedge clk) begin
      if (n_reset) begin
         state_q <= IDLE;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         stall_q <= 1'b0;
         rdy_q   <= 1'b0;
         wpc_q   <= '0;
         wtgt_q  <= '0;
         wtk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         rdy_q   <= 1'b1;
         if (push) wp_q <= wp_q + 1'b1;
         if (rd_ok) begin
            rp_q   <= rp_q + 1'b1;
            wpc_q  <= fpc_q[rp_q[QW-1:0]];
            wtgt_q <= ftgt_q[rp_q[QW-1:0]];
            wtk_q  <= ftk_q[rp_q[QW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fpc_q[wp_q[QW-1:0]]  <= upd_pc[47:2];
         ftgt_q[wp_q[QW-1:0]] <= upd_target;
         ftk_q[wp_q[QW-1:0]]  <= upd_taken;
      end
   end

   // On a not-taken hit the BHT keeps its stored target and ignores bht_wtarget.
   assign upd_ready   = rdy_q && !full && !n_reset;
   assign lu_stall    = stall_q && !n_reset;
   assign busy        = (!empty || state_q != IDLE) && !n_reset;
   assign bht_re      = rd_ok;
   assign bht_ridx    = rd_ok ? fpc_q[rp_q[QW-1:0]][IW-1:0] : '0;
   assign bht_we      = we;
   assign bht_widx    = we ? wpc_q[IW-1:0] : '0;
   assign bht_wtag    = we ? wpc_q[45:IW] : '0;
   assign bht_wtarget = we ? wtgt_q : '0;
   assign bht_wctr    = we ? ctr_nxt : '0;
endmodule
